chan_fifo_sched: RTL and testbench

Parametrised multi-channel write-buffer and scheduler on the memory-mapped slave bus of the VGA peripheral. Host writes to per-channel addresses push bytes into NUM_CH independent FIFOs. A round-robin scheduler drains non-empty FIFOs one entry at a time into a single valid/ready stream tagged with the channel number, for the display pipeline. It generalises the three-FIFO write path to N channels with status readback and downstream backpressure.

---
 rtl/chan_fifo_sched.sv | 148 ++++++++++++++
 tb/tb_chan_fifo_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_fifo_sched.sv
// Multi-channel write buffer with a round-robin drain onto one tagged valid/ready stream.
// Optional sticky overflow flags: define CHAN_FIFO_OVF_STICKY_EN.
module chan_fifo_sched #(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_chan,
  output logic [1:0]        sched_state
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ADVANCE} sched_state_t;

  // Stream handshake: a beat transfers on any edge where out_valid && out_ready;
  // once raised, out_valid/out_data/out_chan hold until that transfer.
  sched_state_t state;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [NUM_CH-1:0] nonempty, full, push_c, pop_c, ovf;
  logic [2:0]        last_grant, grant_ch;
  logic              grant_found, load, wr_en, push_hit;
  logic [DATA_W-1:0] grant_data, status;

  assign wr_en       = chipselect && write;
  assign push_hit    = wr_en && (address != 3'd0) && ({29'd0, address} <= NUM_CH);
  assign load        = !out_valid || out_ready;
  assign sched_state = state;

  always_comb begin
    nonempty   = '0;
    full       = '0;
    push_c     = '0;
    pop_c      = '0;
    grant_found = 1'b0;
    grant_ch   = '0;
    grant_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty[c] = (count[c] != '0);
      full[c]     = (count[c] == CNT_W'(DEPTH));
      push_c[c]   = push_hit && (address == 3'(c + 1)) && !full[c];
    end
    // Search starts just past the last grant and wraps round.
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_found && nonempty[c] && (c == (int'(last_grant) + i) % NUM_CH)) begin
          grant_found = 1'b1;
          grant_ch    = 3'(c);
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_found && (grant_ch == 3'(c))) begin
        grant_data = mem[c][rd_ptr[c]];
        pop_c[c]   = load;
      end
    end
  end

  always_comb begin
    status = '0;
    if (address == 3'd0) begin
      for (int c = 0; c < NUM_CH; c++) status[c] = nonempty[c];
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (address == 3'(c + 1)) status = DATA_W'({ovf[c], full[c], count[c]});
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        for (int d = 0; d < DEPTH; d++) mem[c][d] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_c[c]) begin
          mem[c][wr_ptr[c]] <= writedata;
          wr_ptr[c]         <= wr_ptr[c] + PTR_W'(1);
        end
        if (pop_c[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (push_c[c] && !pop_c[c])      count[c] <= count[c] + CNT_W'(1);
        else if (!push_c[c] && pop_c[c]) count[c] <= count[c] - CNT_W'(1);
      end
    end
  end

`ifdef CHAN_FIFO_OVF_STICKY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_hit && (address == 3'(c + 1)) && full[c]) ovf[c] <= 1'b1;
        else if (wr_en && (address == 3'd0) && writedata[c]) ovf[c] <= 1'b0;
      end
    end
  end
`else
  assign ovf = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= 3'(NUM_CH - 1);
      readdata   <= '0;
    end else begin
      if (chipselect && read) readdata <= status;
      if (load) begin
        if (grant_found) begin
          state      <= S_ADVANCE;
          out_valid  <= 1'b1;
          out_data   <= grant_data;
          out_chan   <= grant_ch;
          last_grant <= grant_ch;
        end else begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      end else begin
        state <= S_HOLD;
      end
    end
  end
endmodule

// File: tb/tb_chan_fifo_sched.sv
// Bench for chan_fifo_sched: directed scenarios plus random traffic against a queue-based model.
module tb_chan_fifo_sched;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef CHAN_FIFO_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clk, reset_n, chipselect, write, read, out_ready;
  logic [2:0]        address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata, out_data;
  logic              out_valid;
  logic [2:0]        out_chan;
  logic [1:0]        sched_state;

  chan_fifo_sched #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata), .readdata(readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .sched_state(sched_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  // reference model: one queue per channel plus the output register
  logic [DATA_W-1:0] mq [NUM_CH][$];
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_chan, m_last;
  logic [DATA_W-1:0] m_rdata;
  bit   [NUM_CH-1:0] m_ovf;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_status(int a);
    int v = 0;
    if (a == 0) begin
      for (int c = 0; c < NUM_CH; c++) if (mq[c].size() > 0) v += (1 << c);
    end else if (a <= NUM_CH) begin
      v = mq[a-1].size();
      if (mq[a-1].size() == DEPTH) v += (1 << CNT_W);
      if (m_ovf[a-1]) v += (1 << (CNT_W + 1));
    end
    return DATA_W'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_last  = NUM_CH - 1;
    m_rdata = '0;
    m_ovf   = '0;
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_chan", out_chan, m_chan);
    end
    check("readdata", readdata, m_rdata);
  endtask

  // one clock: model consumes the inputs the DUT sampled, then outputs are compared
  task automatic step();
    bit phit, pok;
    int pc, g;
    @(posedge clk);
    if (chipselect && read) m_rdata = m_status(int'(address));
    phit = chipselect && write && (address >= 1) && (int'(address) <= NUM_CH);
    pc   = int'(address) - 1;
    pok  = 1'b0;
    if (phit) begin
      pok = (mq[pc].size() < DEPTH);
      if (!pok && STICKY) m_ovf[pc] = 1'b1;
    end
    if (STICKY && chipselect && write && address == 3'd0)
      m_ovf &= ~writedata[NUM_CH-1:0];
    if (!m_valid || out_ready) begin
      g = -1;
      for (int i = 1; i <= NUM_CH; i++)
        if (g < 0 && mq[(m_last + i) % NUM_CH].size() > 0) g = (m_last + i) % NUM_CH;
      if (g >= 0) begin
        m_data  = mq[g].pop_front();
        m_chan  = g;
        m_last  = g;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (pok) mq[pc].push_back(writedata);
    #1;
    compare_outputs();
  endtask

  // driver tasks
  task automatic wr(input logic [2:0] a, input logic [DATA_W-1:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    step();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_chan", out_chan, 3'd0);
    check("rst_readdata", readdata, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, 1'b0);
    check("init_out_data", out_data, '0);
    check("init_out_chan", out_chan, 3'd0);
    check("init_readdata", readdata, '0);
    reset_n = 1'b1;

    // single byte, one-cycle push-to-stream latency
    out_ready = 1'b1;
    wr(3'd1, 8'hA1);
    check("a1_not_yet", out_valid, 1'b0);
    step();
    check("a1_valid", out_valid, 1'b1);
    check("a1_data", out_data, 8'hA1);
    check("a1_chan", out_chan, 3'd0);
    step();
    check("a1_drained", out_valid, 1'b0);

    // one byte per channel under backpressure, then release
    out_ready = 1'b0;
    wr(3'd1, 8'h11); wr(3'd2, 8'h22); wr(3'd3, 8'h33);
    idle(3);
    out_ready = 1'b1;
    idle(5);

    // overflow: stall the output with channel 0, then push 5 to channel 1
    out_ready = 1'b0;
    wr(3'd1, 8'h5A);
    idle(1);
    for (int i = 0; i < 5; i++) wr(3'd2, DATA_W'(8'hC0 + i));
    rd(3'd2);
    check("full_status", readdata, 8'h0C | (STICKY ? 8'h10 : 8'h00));
    wr(3'd0, 8'h02);
    rd(3'd2);
    check("ovf_cleared", readdata, 8'h0C);
    idle(3);
    out_ready = 1'b1;
    idle(8);

    // push on the same edge the last entry is popped
    wr(3'd1, 8'h01);
    wr(3'd1, 8'h05);
    rd(3'd1);
    check("pushpop_count", readdata, 8'h01);
    idle(3);

    // reset while all FIFOs hold data
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(3'(1 + (i % NUM_CH)), DATA_W'($urandom));
    mid_reset();
    out_ready = 1'b1;
    idle(4);
    rd(3'd0);
    check("post_reset_status", readdata, 8'h00);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write      = ($urandom_range(0, 2) != 0);
      read       = ($urandom_range(0, 3) == 0);
      address    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                               : 3'($urandom_range(0, 3));
      writedata  = DATA_W'($urandom);
      out_ready  = ((i % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (i == 1500) mid_reset();
      step();
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
